wash_sequencer: RTL and testbench
=================================

# wash_sequencer

Parametrised successor to the washing-machine state controller. Sequences a programmable list of wash phases (e.g. wash/rinse/spin) with internal tick-driven timers for power-up delay, per-phase duration and finish alarm. Also handles pause, door-open interlock and a latched fault state, and reports the active phase and total remaining time to the display logic.

## Interface
- PHASES, 3: number of program phases (≥1)
- TIME_W, 8: width of each phase duration, in ticks
- INIT_TICKS, 3: power-up delay in BEGIN
- FINISH_TICKS, 5: alarm duration in FINISH
- cp  in  1  system clock, rising edge
- resetBtn  in  1  reset, asynchronous, active-low
- tick  in  1  one-cycle timebase enable (e.g. 1 Hz)
- powerBtn  in  1  one-cycle pulse: power on / abort
- runBtn  in  1  level: 1 = run, 0 = pause
- openBtn  in  1  level: door open
- faultIn  in  1  level: plant fault (water level, motor)
- phaseMask  in  PHASES  enabled phases; bit i = phase i
- phaseTime  in  PHASES*TIME_W  duration of phase i in bits [i*TIME_W +: TIME_W]
- state  out  3  current state code
- phase  out  clog2(PHASES) (min 1)  index of the active phase
- phaseActive  out  PHASES  one-hot active phase; 0 outside RUN/PAUSE
- remaining  out  TIME_W+clog2(PHASES)  sum of the remaining ticks of the active phase and all later latched phases
- doorLock  out  1  high only in RUN
- alarm  out  1  high in FINISH and ERROR

## Operation
- States and codes: SHUTDOWN=0, BEGIN=1, SET=2, RUN=3, ERROR=4, PAUSE=5, FINISH=6. Codes 7 and any illegal code go to SHUTDOWN on the next cycle.
- Reset (asynchronous) sets state=SHUTDOWN. All counters, phase, phaseActive, remaining, doorLock and alarm are 0. Reset mid-run discards all progress.
- SHUTDOWN: powerBtn → BEGIN and load initCnt=INIT_TICKS.
- BEGIN: each tick decrements initCnt. When initCnt==0 → SET. With INIT_TICKS=0 the block leaves on the next clock.
- SET:
  - runBtn && !openBtn && phaseMask!=0 → RUN.
  - On that edge, latch phaseMask into maskQ and every phaseTime slice into its phase counter.
  - phase = lowest set bit of maskQ.
  - With phaseMask==0 the block stays in SET.
- RUN, priority top down:
  1. faultIn → ERROR.
  2. openBtn or !runBtn → PAUSE.
  3. tick with the active counter >1: decrement it.
  4. tick with the active counter ≤1: clear it and advance phase to the next higher set bit of maskQ. If there is none, → FINISH and load finishCnt=FINISH_TICKS.
  - A zero duration therefore lasts exactly one tick.
- PAUSE:
  - faultIn → ERROR.
  - powerBtn → SHUTDOWN (abort).
  - runBtn && !openBtn → RUN.
  - Counters and phase are retained.
- FINISH: each tick decrements finishCnt. At 0 → SHUTDOWN.
- ERROR: held until powerBtn → SHUTDOWN. faultIn deassertion alone does not exit.
- powerBtn is ignored in BEGIN, SET, RUN and FINISH.
- tick is ignored in SHUTDOWN, SET, PAUSE and ERROR.
- remaining counts masked-off phases as 0 and is 0 outside RUN/PAUSE. Sum width TIME_W+clog2(PHASES) guarantees no overflow.

## Timing
- All transitions are registered: an input sampled at edge n changes state at edge n.
- state, phase, phaseActive, doorLock and alarm are decoded from registers with no combinational path from inputs.
- remaining is combinational from the counter registers only. It is valid in the same cycle as the counters.
- Phase advance takes 1 cycle: the new phaseActive appears on the edge that consumes the final tick.
- When a tick coincides with a pause/fault request, the tick is dropped and the counter does not decrement.
- A tick in the cycle that enters BEGIN or FINISH does not count (the counter is only loaded on that edge).

## Structure
- Shared package wm_pkg holds:
  - the state code localparams (SHUTDOWN..FINISH);
  - the 3-bit state width;
  - a next_set_bit(mask, idx) function, shared with the display decoder.
- Natural sub-module phase_counter:
  - TIME_W-bit down-counter with load, dec and le1 (≤1) flag;
  - instantiated PHASES times by generate.
- initCnt and finishCnt can share one counter, sized to hold max(INIT_TICKS, FINISH_TICKS).

## Test plan
- Power-up and delay: powerBtn, then 3 ticks → state 0→1, then 2 on the cycle after the 3rd tick. No change before the 3rd tick.
- Full program: PHASES=3, mask=3'b111, times {2,1,3}, run with 6 ticks.
  - remaining steps 6,5,4,3,2,1.
  - phaseActive 001→010→100.
  - state 6 after the 6th tick, alarm=1.
  - state 0 after 5 more ticks.
- Masked phase and zero time: mask=3'b101, times {0,9,4} → phase 0 lasts 1 tick, phase 1 is skipped, phase 2 lasts 4 ticks. Initial remaining=5.
- Pause/door: in RUN with remaining=4, assert openBtn on the same cycle as a tick.
  - state 5, remaining stays 4, doorLock=0.
  - Release openBtn → state 3, and the program resumes with remaining=4.
- Fault latch: faultIn in PAUSE → state 4, alarm=1. The block stays in 4 after faultIn drops; powerBtn → state 0.
- Async reset mid-RUN: pulse resetBtn low between clock edges → state, remaining and phaseActive are 0 immediately, and the block stays in SHUTDOWN until powerBtn.

Source files
------------

// File: rtl/wm_pkg.sv
// Shared washing-machine definitions: state codes, state width and the
// phase-mask scan helper used by the sequencer and the display decoder.
package wm_pkg;

    localparam int STATE_W = 3;

    localparam logic [STATE_W-1:0] SHUTDOWN = 3'd0;
    localparam logic [STATE_W-1:0] BEGIN    = 3'd1;
    localparam logic [STATE_W-1:0] SET      = 3'd2;
    localparam logic [STATE_W-1:0] RUN      = 3'd3;
    localparam logic [STATE_W-1:0] ERROR    = 3'd4;
    localparam logic [STATE_W-1:0] PAUSE    = 3'd5;
    localparam logic [STATE_W-1:0] FINISH   = 3'd6;

    typedef enum logic [STATE_W-1:0] {
        stShutdown = SHUTDOWN,
        stBegin    = BEGIN,
        stSet      = SET,
        stRun      = RUN,
        stError    = ERROR,
        stPause    = PAUSE,
        stFinish   = FINISH
    } state_e;

    // Lowest set bit of mask strictly above idx, or -1 if none.
    // Pass idx = -1 to get the lowest set bit overall.
    function automatic int next_set_bit(logic [31:0] mask, int idx);
        int r;
        r = -1;
        for (int i = 31; i >= 0; i--) begin
            if (mask[i] && i > idx) r = i;
        end
        return r;
    endfunction

endpackage

// File: rtl/wash_sequencer_if.sv
// Control/status bundle between the panel/plant and the wash sequencer.
// master: drives buttons, timebase and program; slave: reports status.
interface wash_sequencer_if
    import wm_pkg::*;
#(
    parameter int PHASES = 3,
    parameter int TIME_W = 8
);
    localparam int PW = (PHASES > 1) ? $clog2(PHASES) : 1;
    localparam int RW = TIME_W + $clog2(PHASES);

    logic                     tick;
    logic                     powerBtn;
    logic                     runBtn;
    logic                     openBtn;
    logic                     faultIn;
    logic [PHASES-1:0]        phaseMask;
    logic [PHASES*TIME_W-1:0] phaseTime;
    logic [STATE_W-1:0]       state;
    logic [PW-1:0]            phase;
    logic [PHASES-1:0]        phaseActive;
    logic [RW-1:0]            remaining;
    logic                     doorLock;
    logic                     alarm;

    modport master (
        output tick, powerBtn, runBtn, openBtn, faultIn,
        output phaseMask, phaseTime,
        input  state, phase, phaseActive, remaining,
        input  doorLock, alarm
    );

    modport slave (
        input  tick, powerBtn, runBtn, openBtn, faultIn,
        input  phaseMask, phaseTime,
        output state, phase, phaseActive, remaining,
        output doorLock, alarm
    );

endinterface

// File: rtl/phase_counter.sv
// Per-phase duration down-counter with load, decrement and a <=1 flag.
// Ports: clk, rst_n, load/loadVal, dec; outputs cnt and le1.
module phase_counter #(
    parameter int TIME_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic [TIME_W-1:0] loadVal,
    input  logic              dec,
    output logic [TIME_W-1:0] cnt,
    output logic              le1
);

    assign le1 = (cnt <= TIME_W'(1));

    // The final tick of a phase clears the counter, so 0 and 1 both end at 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= loadVal;
        end else if (dec) begin
            cnt <= le1 ? '0 : cnt - TIME_W'(1);
        end
    end

endmodule

// File: rtl/wash_sequencer.sv
// Washing-machine program sequencer: power-up delay, masked phase list,
// pause/door interlock, latched fault and finish alarm.
// Ports: cp, resetBtn (async active-low), bus (wash_sequencer_if.slave).
module wash_sequencer
    import wm_pkg::*;
#(
    parameter int PHASES       = 3,
    parameter int TIME_W       = 8,
    parameter int INIT_TICKS   = 3,
    parameter int FINISH_TICKS = 5
) (
    input  logic             cp,
    input  logic             resetBtn,
    wash_sequencer_if.slave  bus
);

    localparam int PW   = (PHASES > 1) ? $clog2(PHASES) : 1;
    localparam int RW   = TIME_W + $clog2(PHASES);
    localparam int MAXT = (INIT_TICKS > FINISH_TICKS) ? INIT_TICKS : FINISH_TICKS;
    localparam int CW   = (MAXT > 0) ? $clog2(MAXT + 1) : 1;

    state_e            stateQ;
    logic [CW-1:0]     tCnt;
    logic [PHASES-1:0] maskQ;
    logic [PW-1:0]     phaseQ;

    logic [TIME_W-1:0] cnt [PHASES];
    logic [PHASES-1:0] le1;
    logic [PHASES-1:0] decEn;
    logic              runOk;
    logic              loadEn;
    logic              advance;
    logic              le1Act;
    logic              inRunPause;
    int                firstIdx;
    int                nxtIdx;
    logic [RW-1:0]     remSum;

    assign runOk   = bus.runBtn && !bus.openBtn;
    assign loadEn  = (stateQ == stSet) && runOk && (|bus.phaseMask);
    // Pause and fault take precedence, so a coincident tick is dropped.
    assign advance = (stateQ == stRun) && !bus.faultIn && runOk && bus.tick;
    assign le1Act  = le1[phaseQ];

    always_comb begin
        firstIdx = next_set_bit(32'(bus.phaseMask), -1);
        nxtIdx   = next_set_bit(32'(maskQ), int'(phaseQ));
    end

    for (genvar i = 0; i < PHASES; i++) begin : gPhase
        assign decEn[i] = advance && (phaseQ == PW'(i));

        phase_counter #(
            .TIME_W(TIME_W)
        ) uCnt (
            .clk    (cp),
            .rst_n  (resetBtn),
            .load   (loadEn),
            .loadVal(bus.phaseTime[i*TIME_W +: TIME_W]),
            .dec    (decEn[i]),
            .cnt    (cnt[i]),
            .le1    (le1[i])
        );
    end

    always_ff @(posedge cp or negedge resetBtn) begin
        if (!resetBtn) begin
            stateQ <= stShutdown;
            tCnt   <= '0;
            maskQ  <= '0;
            phaseQ <= '0;
        end else begin
            unique case (stateQ)
                stShutdown: begin
                    phaseQ <= '0;
                    if (bus.powerBtn) begin
                        stateQ <= stBegin;
                        tCnt   <= CW'(INIT_TICKS);
                    end
                end
                stBegin: begin
                    if (tCnt == '0)    stateQ <= stSet;
                    else if (bus.tick) tCnt <= tCnt - CW'(1);
                end
                stSet: begin
                    if (loadEn) begin
                        stateQ <= stRun;
                        maskQ  <= bus.phaseMask;
                        phaseQ <= PW'(firstIdx);
                    end
                end
                stRun: begin
                    if (bus.faultIn) begin
                        stateQ <= stError;
                    end else if (!runOk) begin
                        stateQ <= stPause;
                    end else if (bus.tick && le1Act) begin
                        if (nxtIdx < 0) begin
                            stateQ <= stFinish;
                            tCnt   <= CW'(FINISH_TICKS);
                        end else begin
                            phaseQ <= PW'(nxtIdx);
                        end
                    end
                end
                stPause: begin
                    if (bus.faultIn)       stateQ <= stError;
                    else if (bus.powerBtn) stateQ <= stShutdown;
                    else if (runOk)        stateQ <= stRun;
                end
                stFinish: begin
                    if (tCnt == '0)    stateQ <= stShutdown;
                    else if (bus.tick) tCnt <= tCnt - CW'(1);
                end
                stError: begin
                    if (bus.powerBtn) stateQ <= stShutdown;
                end
                default: stateQ <= stShutdown;
            endcase
        end
    end

    assign inRunPause = (stateQ == stRun) || (stateQ == stPause);

    // A pending zero-duration phase still costs one tick, so it shows as 1;
    // remaining then equals the ticks left until FINISH.
    always_comb begin
        remSum = '0;
        for (int i = 0; i < PHASES; i++) begin
            if (maskQ[i] && i >= int'(phaseQ)) begin
                remSum = remSum + (le1[i] ? RW'(1) : RW'(cnt[i]));
            end
        end
    end

    assign bus.state       = stateQ;
    assign bus.phase       = phaseQ;
    assign bus.phaseActive = inRunPause ? (PHASES'(1) << phaseQ) : '0;
    assign bus.remaining   = inRunPause ? remSum : '0;
    assign bus.doorLock    = (stateQ == stRun);
    assign bus.alarm       = (stateQ == stFinish) || (stateQ == stError);

endmodule

// File: tb/tb_wash_sequencer.sv
// Self-checking bench for wash_sequencer: directed and random programs
// compared against a ticks-to-finish reference model.
module tb_wash_sequencer;

    logic cp = 1'b0;
    logic resetBtn;
    int   total = 0;
    int   bad   = 0;

    int       dur [3];
    logic [2:0] mask;
    int       consumed;
    int       sumDur;

    wash_sequencer_if #(.PHASES(3), .TIME_W(8)) bus ();

    wash_sequencer #(
        .PHASES      (3),
        .TIME_W      (8),
        .INIT_TICKS  (3),
        .FINISH_TICKS(5)
    ) dut (
        .cp      (cp),
        .resetBtn(resetBtn),
        .bus     (bus)
    );

    always #5 cp = ~cp;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0d want %0d", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge cp);
        #1;
    endtask

    // Phase whose tick window holds the next tick to be consumed.
    function automatic int activeIdx();
        int acc;
        acc = 0;
        for (int i = 0; i < 3; i++) begin
            if (mask[i]) begin
                acc += dur[i];
                if (consumed < acc) return i;
            end
        end
        return -1;
    endfunction

    task automatic checkProgress(input string tag, input int st);
        int a;
        a = activeIdx();
        check({tag, ".state"}, 32'(bus.state), st);
        check({tag, ".rem"}, 32'(bus.remaining), sumDur - consumed);
        check({tag, ".onehot"}, 32'(bus.phaseActive), 32'(1) << a);
        check({tag, ".phase"}, 32'(bus.phase), a);
        check({tag, ".lock"}, 32'(bus.doorLock), (st == 3) ? 1 : 0);
    endtask

    task automatic powerUp();
        bus.powerBtn = 1'b1;
        cyc();
        bus.powerBtn = 1'b0;
        check("pwr.begin", 32'(bus.state), 1);
        for (int k = 0; k < 3; k++) begin
            cyc();
            check("pwr.idle", 32'(bus.state), 1);
            bus.tick = 1'b1;
            cyc();
            bus.tick = 1'b0;
            check("pwr.tick", 32'(bus.state), 1);
        end
        cyc();
        check("pwr.set", 32'(bus.state), 2);
    endtask

    task automatic runProgram(input logic [2:0] m, input int t0,
                              input int t1, input int t2, input int pauseAt);
        int t [3];
        t[0] = t0;
        t[1] = t1;
        t[2] = t2;
        mask   = m;
        sumDur = 0;
        for (int i = 0; i < 3; i++) begin
            dur[i] = m[i] ? ((t[i] < 1) ? 1 : t[i]) : 0;
            sumDur += dur[i];
        end
        consumed = 0;
        bus.phaseMask = m;
        bus.phaseTime = {8'(t2), 8'(t1), 8'(t0)};
        bus.runBtn    = 1'b1;
        bus.openBtn   = 1'b0;
        cyc();
        checkProgress("start", 3);
        while (consumed < sumDur) begin
            if (consumed == pauseAt) begin
                bus.openBtn = 1'b1;
                bus.tick    = 1'b1;
                cyc();
                bus.tick = 1'b0;
                checkProgress("pause", 5);
                bus.openBtn = 1'b0;
                cyc();
                checkProgress("resume", 3);
            end
            bus.tick = 1'b1;
            cyc();
            bus.tick = 1'b0;
            consumed++;
            if (consumed < sumDur) checkProgress("run", 3);
        end
        check("fin.state", 32'(bus.state), 6);
        check("fin.alarm", 32'(bus.alarm), 1);
        check("fin.rem", 32'(bus.remaining), 0);
        check("fin.onehot", 32'(bus.phaseActive), 0);
        check("fin.lock", 32'(bus.doorLock), 0);
        bus.runBtn = 1'b0;
        for (int k = 0; k < 5; k++) begin
            bus.powerBtn = (k == 0);
            cyc();
            bus.powerBtn = 1'b0;
            bus.tick = 1'b1;
            cyc();
            bus.tick = 1'b0;
            check("fin.hold", 32'(bus.state), 6);
        end
        cyc();
        check("fin.off", 32'(bus.state), 0);
        check("fin.alarmoff", 32'(bus.alarm), 0);
    endtask

    initial begin
        logic [2:0] rm;
        resetBtn      = 1'b0;
        bus.tick      = 1'b0;
        bus.powerBtn  = 1'b0;
        bus.runBtn    = 1'b0;
        bus.openBtn   = 1'b0;
        bus.faultIn   = 1'b0;
        bus.phaseMask = '0;
        bus.phaseTime = '0;
        mask          = '0;
        consumed      = 0;
        sumDur        = 0;
        repeat (2) cyc();
        check("rst.state", 32'(bus.state), 0);
        check("rst.rem", 32'(bus.remaining), 0);
        check("rst.onehot", 32'(bus.phaseActive), 0);
        check("rst.phase", 32'(bus.phase), 0);
        check("rst.lock", 32'(bus.doorLock), 0);
        check("rst.alarm", 32'(bus.alarm), 0);
        resetBtn = 1'b1;
        bus.tick = 1'b1;
        cyc();
        bus.tick = 1'b0;
        check("idle.state", 32'(bus.state), 0);

        // Full program with empty-mask and door-open holds in SET
        powerUp();
        bus.runBtn = 1'b1;
        cyc();
        check("set.nomask", 32'(bus.state), 2);
        bus.phaseMask = 3'b111;
        bus.openBtn   = 1'b1;
        cyc();
        check("set.door", 32'(bus.state), 2);
        bus.openBtn = 1'b0;
        bus.runBtn  = 1'b0;
        cyc();
        runProgram(3'b111, 2, 1, 3, -1);

        // Masked phase, zero duration, pause on a tick at remaining=4
        powerUp();
        runProgram(3'b101, 0, 9, 4, 1);

        // Random programs
        for (int r = 0; r < 4; r++) begin
            powerUp();
            rm = 3'($urandom_range(1, 7));
            runProgram(rm, int'($urandom_range(0, 6)),
                       int'($urandom_range(0, 6)),
                       int'($urandom_range(0, 6)),
                       int'($urandom_range(0, 3)));
        end

        // Fault latch from PAUSE
        powerUp();
        bus.phaseMask = 3'b111;
        bus.phaseTime = {8'd5, 8'd5, 8'd5};
        bus.runBtn    = 1'b1;
        cyc();
        check("flt.run", 32'(bus.state), 3);
        bus.tick = 1'b1;
        cyc();
        bus.tick   = 1'b0;
        bus.runBtn = 1'b0;
        cyc();
        check("flt.pause", 32'(bus.state), 5);
        check("flt.rem", 32'(bus.remaining), 14);
        bus.faultIn = 1'b1;
        cyc();
        check("flt.err", 32'(bus.state), 4);
        check("flt.alarm", 32'(bus.alarm), 1);
        bus.faultIn = 1'b0;
        bus.runBtn  = 1'b1;
        cyc();
        check("flt.hold", 32'(bus.state), 4);
        bus.powerBtn = 1'b1;
        cyc();
        bus.powerBtn = 1'b0;
        check("flt.off", 32'(bus.state), 0);

        // Asynchronous reset mid-RUN
        powerUp();
        bus.phaseTime = {8'($urandom_range(1, 9)), 8'd4, 8'd3};
        bus.runBtn    = 1'b1;
        cyc();
        bus.tick = 1'b1;
        cyc();
        bus.tick = 1'b0;
        check("ar.run", 32'(bus.state), 3);
        #3;
        resetBtn = 1'b0;
        #1;
        check("ar.state", 32'(bus.state), 0);
        check("ar.rem", 32'(bus.remaining), 0);
        check("ar.onehot", 32'(bus.phaseActive), 0);
        #2;
        resetBtn = 1'b1;
        for (int k = 0; k < 3; k++) begin
            bus.tick = 1'b1;
            cyc();
            check("ar.stay", 32'(bus.state), 0);
        end
        bus.tick     = 1'b0;
        bus.powerBtn = 1'b1;
        cyc();
        bus.powerBtn = 1'b0;
        check("ar.pwr", 32'(bus.state), 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
